vga_capture: RTL
================

// Module: vga_capture
// PURPOSE
//  Receive-side counterpart of the VGA sync generator: samples VGA_HS/VGA_VS/VGA_R/G/B on the pixel clock.
//  Recovers active-area pixel coordinates, measures line length and lines per frame, and declares lock.
//  Emits a registered pixel stream (valid + X/Y + RGB) for a frame checker or buffer writer downstream.
//  In loopback it sits directly after vga_sync plus the pattern generator, on the same vga_clk.
// PARAMETERS
//  H_START     144  pixel index (0 = first HS-low sample) of first active pixel (sync 96 + back porch 48)
//  H_ACTIVE    640  active pixels per line
//  H_TOTAL     800  expected pixel clocks per line
//  V_START     35   line index (0 = first line after VS fall) of first active line (sync 2 + back porch 33)
//  V_ACTIVE    480  active lines per frame
//  V_TOTAL     525  expected lines per frame
//  LOCK_FRAMES 2    consecutive matching frames required to assert LOCKED (1..15)
// PORTS
//  CLK          in   1   pixel clock (vga_clk), rising edge
//  RST          in   1   asynchronous, active-high reset
//  VGA_HS       in   1   horizontal sync, active low
//  VGA_VS       in   1   vertical sync, active low
//  VGA_R/G/B    in   4   colour components, each 4 bits
//  PIX_VALID    out  1   PIX_* hold an active-area pixel of a locked frame
//  PIX_X        out  11  active column 0..H_ACTIVE-1
//  PIX_Y        out  11  active row 0..V_ACTIVE-1
//  PIX_R/G/B    out  4   captured colour, each 4 bits
//  FRAME_START  out  1   one-cycle pulse coincident with PIX_VALID for pixel (0,0)
//  LOCKED       out  1   timing matches H_TOTAL/V_TOTAL
//  LINE_LEN     out  11  last measured HS-fall-to-HS-fall period in clocks
//  FRAME_LINES  out  11  last measured VS-fall-to-VS-fall period in lines
// BEHAVIOUR
//  - Reset: every output 0; internal counters 0; FSM = SEARCH. RST asserted mid-frame aborts instantly (async).
//  - Input stage: all pins registered once (s1); s1 is registered again (s2) for edge detect.
//    HS fall = s1_hs=0 & s2_hs=1; likewise VS.
//  - h_idx: 11 bits; 0 on the s1 sample that is the HS fall, +1 per clock, saturates at 2047.
//  - v_idx: 11 bits; increments on each HS fall, cleared to 0 on the HS fall following a VS fall,
//    saturates at 2047. VS fall and HS fall in the same cycle: VS clear wins; that line is line 0.
//  - On HS fall: LINE_LEN <= h_idx+1 of the ending line (ignored if saturated).
//  - On VS fall: FRAME_LINES <= v_idx+1 (ignored if saturated).
//  - Output latency: 2 clocks from pin to PIX_* (s1 register + output register); all outputs registered.
//  - PIX_VALID = LOCKED & H_START<=h_idx<H_START+H_ACTIVE & V_START<=v_idx<V_START+V_ACTIVE.
//    PIX_X = h_idx-H_START; PIX_Y = v_idx-V_START; PIX_X/Y/RGB hold previous values while invalid.
//  - FSM:
//    SEARCH  -> MEASURE on first VS fall; good-frame count = 0.
//    MEASURE: each line end checks LINE_LEN==H_TOTAL; each VS fall checks FRAME_LINES==V_TOTAL.
//             Both ok for the frame -> count+1; count==LOCK_FRAMES -> LOCKED.
//             Any mismatch -> SEARCH.
//    LOCKED:  LOCKED=1. Any line-length or frame-length mismatch, or h_idx/v_idx saturation (sync lost),
//             -> SEARCH with LOCKED=0 on the next clock. PIX_VALID drops in the same cycle.
//  - LOCKED rises at the VS fall completing the LOCK_FRAMES-th good frame.
//    The first valid pixel is (0,0) of the following frame, never a partial frame.
//  - HS glitch (extra fall mid-line): mismatch -> unlock. No recovery within the current frame.
// STRUCTURE
//  - Shared include vga_timing.vh: 640x480 constants (H_SYNC=96, H_BP=48, H_ACTIVE, H_TOTAL, V_SYNC=2,
//    V_BP=33, V_ACTIVE, V_TOTAL); vga_sync also uses it. FSM state encodings are local parameters.
//  - One sub-module, sync_edge_detect: 2-flop register plus falling-edge pulse; instantiated for HS and VS.
//  - Remaining logic in vga_capture: counters, measurement registers, lock FSM, output register.
// TESTING
//  1 Reset: RST high mid-stream -> all outputs 0 within the same cycle; LOCKED=0, PIX_VALID=0.
//  2 Standard 640x480 from vga_sync + rectangle pattern:
//    LOCKED after 2 full frames; LINE_LEN=800, FRAME_LINES=525;
//    exactly 307200 PIX_VALID per frame; FRAME_START once per frame.
//  3 Pixel alignment: drive R=h_idx[3:0] pattern -> PIX_X==0 carries the pin value driven
//    144 clocks after HS fall; 2-clock pin-to-output latency; PIX_Y=479 on the last active line.
//  4 Wrong timing: H_TOTAL 801 clocks/line -> LINE_LEN=801, LOCKED never asserts.
//    Switch to 800 -> LOCKED after 2 frames.
//  5 Sync loss while locked: hold HS high for 2100 clocks -> LOCKED and PIX_VALID drop when h_idx saturates.
//    Restore HS -> relock after 2 good frames.
//  6 Simultaneous HS/VS fall: v_idx=0 on that line; FRAME_LINES=525; lock unaffected.

Source files
------------

// File: rtl/vga_capture_pkg.sv
// Shared 640x480 timing constants, index type and lock-FSM states for the VGA capture block.
package vga_capture_pkg;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_TOTAL  = VGA_H_SYNC + VGA_H_BP + VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_TOTAL  = VGA_V_SYNC + VGA_V_BP + VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_H_START  = VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_START  = VGA_V_SYNC + VGA_V_BP;

    localparam int CW = 11;
    typedef logic [CW-1:0] idx_t;
    localparam idx_t IDX_MAX = '1;

    typedef enum logic [1:0] {
        S_SEARCH  = 2'd0,
        S_MEASURE = 2'd1,
        S_LOCKED  = 2'd2
    } cap_state_e;

    function automatic idx_t sat_inc(input idx_t v);
        return (v == IDX_MAX) ? v : v + idx_t'(1);
    endfunction
endpackage

// File: rtl/vga_capture_if.sv
// VGA pin bundle into the capture block and the recovered pixel stream / status out of it.
interface vga_capture_if;
    import vga_capture_pkg::*;

    logic       VGA_HS;
    logic       VGA_VS;
    logic [3:0] VGA_R;
    logic [3:0] VGA_G;
    logic [3:0] VGA_B;
    logic       PIX_VALID;
    idx_t       PIX_X;
    idx_t       PIX_Y;
    logic [3:0] PIX_R;
    logic [3:0] PIX_G;
    logic [3:0] PIX_B;
    logic       FRAME_START;
    logic       LOCKED;
    idx_t       LINE_LEN;
    idx_t       FRAME_LINES;

    modport master (
        output VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B,
        input  PIX_VALID, PIX_X, PIX_Y, PIX_R, PIX_G, PIX_B,
        input  FRAME_START, LOCKED, LINE_LEN, FRAME_LINES
    );
    modport slave (
        input  VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B,
        output PIX_VALID, PIX_X, PIX_Y, PIX_R, PIX_G, PIX_B,
        output FRAME_START, LOCKED, LINE_LEN, FRAME_LINES
    );
endinterface

// File: rtl/vga_capture_sync_edge_detect.sv
// Two-flop sampler on an active-low sync pin with a one-cycle falling-edge pulse.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic fall_o
);
    logic s1_q, s2_q;

    // Idle (high) reset value so a pin already low out of reset is seen as a fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign fall_o = ~s1_q & s2_q;
endmodule

// File: rtl/vga_capture.sv
// VGA receiver: recovers pixel coordinates from HS/VS, measures line/frame length, locks, emits pixels.
module vga_capture
    import vga_capture_pkg::*;
#(
    parameter int H_START     = VGA_H_START,
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int V_START     = VGA_V_START,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int LOCK_FRAMES = 2
) (
    input  logic      CLK,
    input  logic      RST,
    vga_capture_if.slave bus
);
    localparam idx_t        HS_LO  = idx_t'(H_START);
    localparam idx_t        HS_HI  = idx_t'(H_START + H_ACTIVE);
    localparam idx_t        VS_LO  = idx_t'(V_START);
    localparam idx_t        VS_HI  = idx_t'(V_START + V_ACTIVE);
    localparam logic [CW:0] HTOT_W = (CW+1)'(H_TOTAL);
    localparam logic [CW:0] VTOT_W = (CW+1)'(V_TOTAL);
    localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

    logic        hs_fall, vs_fall;
    logic [3:0]  r_q, g_q, b_q;
    idx_t        h_q, h_cur, v_q, v_cur;
    logic        vs_pend_q, vs_pend_d;
    logic [CW:0] line_len_w, frame_len_w;
    logic        line_ok, frame_ok, bad;
    cap_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        valid_d, valid_q, fs_q;
    idx_t        x_q, y_q, len_q, lines_q;
    logic [3:0]  pr_q, pg_q, pb_q;

    sync_edge_detect u_hs (.clk(CLK), .rst(RST), .d_i(bus.VGA_HS), .fall_o(hs_fall));
    sync_edge_detect u_vs (.clk(CLK), .rst(RST), .d_i(bus.VGA_VS), .fall_o(vs_fall));

    // h_q/v_q hold the index of the previous s1 sample; *_cur is the index of the current one.
    always_comb begin
        h_cur     = hs_fall ? '0 : sat_inc(h_q);
        v_cur     = v_q;
        vs_pend_d = vs_pend_q | vs_fall;
        if (hs_fall) begin
            v_cur     = (vs_fall || vs_pend_q) ? '0 : sat_inc(v_q);
            vs_pend_d = 1'b0;
        end
    end

    assign line_len_w  = {1'b0, h_q} + (CW+1)'(1);
    assign frame_len_w = {1'b0, v_q} + (CW+1)'(1);
    assign line_ok     = (h_q != IDX_MAX) && (line_len_w == HTOT_W);
    assign frame_ok    = (v_q != IDX_MAX) && (frame_len_w == VTOT_W);
    assign bad         = (hs_fall && !line_ok) || (vs_fall && !frame_ok) ||
                         (h_cur == IDX_MAX) || (v_cur == IDX_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_SEARCH: begin
                if (vs_fall) begin
                    state_d = S_MEASURE;
                    cnt_d   = '0;
                end
            end
            S_MEASURE: begin
                if (bad) begin
                    state_d = S_SEARCH;
                end else if (vs_fall) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_d == LOCK_N) state_d = S_LOCKED;
                end
            end
            S_LOCKED: if (bad) state_d = S_SEARCH;
            default:  state_d = S_SEARCH;
        endcase
    end

    // Gated by the next state so PIX_VALID falls on the same clock as LOCKED.
    assign valid_d = (state_d == S_LOCKED) &&
                     (h_cur >= HS_LO) && (h_cur < HS_HI) &&
                     (v_cur >= VS_LO) && (v_cur < VS_HI);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            h_q       <= '0;
            v_q       <= '0;
            vs_pend_q <= 1'b0;
            state_q   <= S_SEARCH;
            cnt_q     <= '0;
        end else begin
            r_q       <= bus.VGA_R;
            g_q       <= bus.VGA_G;
            b_q       <= bus.VGA_B;
            h_q       <= h_cur;
            v_q       <= v_cur;
            vs_pend_q <= vs_pend_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            pr_q    <= '0;
            pg_q    <= '0;
            pb_q    <= '0;
            len_q   <= '0;
            lines_q <= '0;
        end else begin
            valid_q <= valid_d;
            fs_q    <= valid_d && (h_cur == HS_LO) && (v_cur == VS_LO);
            if (valid_d) begin
                x_q  <= h_cur - HS_LO;
                y_q  <= v_cur - VS_LO;
                pr_q <= r_q;
                pg_q <= g_q;
                pb_q <= b_q;
            end
            if (hs_fall && h_q != IDX_MAX) len_q   <= line_len_w[CW-1:0];
            if (vs_fall && v_q != IDX_MAX) lines_q <= frame_len_w[CW-1:0];
        end
    end

    assign bus.PIX_VALID   = valid_q;
    assign bus.PIX_X       = x_q;
    assign bus.PIX_Y       = y_q;
    assign bus.PIX_R       = pr_q;
    assign bus.PIX_G       = pg_q;
    assign bus.PIX_B       = pb_q;
    assign bus.FRAME_START = fs_q;
    assign bus.LOCKED      = (state_q == S_LOCKED);
    assign bus.LINE_LEN    = len_q;
    assign bus.FRAME_LINES = lines_q;
endmodule
